uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receive driver and consumes its byte stream (data plus a one-cycle valid pulse).
- Assembles fixed-length command frames and checks them.
- Issues single-cycle register-write strobes to the filter control register bank.
- Optionally returns an ACK/NAK byte through the UART transmit driver's write-request interface.

Parameters:
- SYSCLKHZ, 25_000_000, system clock frequency in Hz.
- TIMEOUT_CYC, SYSCLKHZ/1000, inter-byte timeout in clock cycles (1 ms at default). Counter width is $clog2(TIMEOUT_CYC+1).
- SOF0, 8'h55, first start-of-frame byte.
- SOF1, 8'hAA, second start-of-frame byte.

Ports:
- I_clk  input  1  system clock.
- I_rstn  input  1  asynchronous active-low reset.
- I_rx_data  input  8  received byte from the UART receive driver.
- I_rx_valid  input  1  one-cycle pulse; I_rx_data is valid this cycle.
- O_reg_wen  output  1  one-cycle register write strobe.
- O_reg_addr  output  8  register address; held stable until the next write.
- O_reg_wdata  output  16  register data; held stable until the next write.
- O_err_cnt  output  8  saturating frame-error counter.
- O_tx_wreq  output  1  transmit request to the UART transmit driver (ACK feature only).
- O_tx_wdata  output  8  transmit byte.
- I_tx_wbusy  input  1  UART transmit driver busy flag.

Behaviour:
- Reset: one clock, reset asynchronous active-low. All outputs are 0 and the FSM is in S_IDLE. Reset mid-frame discards the partial frame; no strobe or response is produced.
- Frame format: SOF0, SOF1, ADDR, DATA_H, DATA_L, CHK.
  - CHK = (ADDR + DATA_H + DATA_L) mod 256.
- FSM states: S_IDLE, S_SOF1, S_ADDR, S_DH, S_DL, S_CHK. Transitions occur only on I_rx_valid:
  - S_IDLE: byte == SOF0 -> S_SOF1; any other byte is ignored and does not count as an error.
  - S_SOF1: byte == SOF1 -> S_ADDR; byte == SOF0 -> stay in S_SOF1 (resync); otherwise -> S_IDLE, no error.
  - S_ADDR, S_DH, S_DL: latch the byte into a shadow register and advance to the next state.
  - S_CHK: go to S_IDLE in all cases.
    - Checksum match: O_reg_wen = 1 for exactly one cycle, starting the cycle after the CHK byte's I_rx_valid. O_reg_addr and O_reg_wdata = {DATA_H, DATA_L} update in that same cycle.
    - Checksum mismatch: no strobe; O_err_cnt increments.
- Timeout:
  - The counter runs in every state except S_IDLE and clears on each I_rx_valid.
  - When it reaches TIMEOUT_CYC: FSM -> S_IDLE and O_err_cnt increments.
  - If I_rx_valid arrives in the same cycle the count would expire, the byte wins: it is processed normally and the counter clears.
- O_err_cnt saturates at 8'hFF. It clears only on reset.
- Back-to-back frames are accepted with no gap cycles; I_rx_valid may assert in the cycle O_reg_wen is high.

Optional Feature:
- Macro: UART_FRAME_ACK_EN.
- Defined: after each completed frame, a response byte is queued.
  - Response byte: 8'h06 (ACK) on a good checksum, 8'h15 (NAK) on a bad checksum. A timeout produces no response.
  - A one-entry pending register holds the byte.
  - O_tx_wreq is a one-cycle pulse, issued in the first cycle the entry is pending and I_tx_wbusy = 0. O_tx_wdata is valid that same cycle.
  - If a new response is generated while one is still pending, the newer response overwrites it.
- Undefined: O_tx_wreq and O_tx_wdata are tied to 0, I_tx_wbusy is unused, and no pending logic is synthesised.

Decomposition:
- Package uart_frame_pkg holds:
  - the FSM state encoding;
  - frame constants SOF0/SOF1 defaults, ACK_BYTE = 8'h06, NAK_BYTE = 8'h15;
  - FRAME_LEN = 6.
- One sub-module, uart_frame_timeout: the inter-byte timeout counter. Inputs: enable, clear. Output: expire pulse.
- The FSM, checksum and response logic stay in the top.

Test Plan:
- Good frame: send 55 AA 03 12 34 49 -> one O_reg_wen pulse with O_reg_addr = 8'h03, O_reg_wdata = 16'h1234, O_err_cnt = 0; with ACK enabled, one O_tx_wreq with O_tx_wdata = 8'h06.
- Bad checksum: send 55 AA 03 12 34 48 -> no O_reg_wen, O_err_cnt = 1; with ACK enabled, O_tx_wdata = 8'h15.
- Timeout recovery: send 55 AA 03, then idle 25000 cycles -> O_err_cnt = 1 and FSM in S_IDLE; then send 55 AA 07 00 FF 06 -> write to addr 8'h07 with data 16'h00FF.
- Resync and noise: send 11 55 55 AA 01 AB CD 79 -> exactly one write, addr 8'h01, data 16'hABCD, O_err_cnt unchanged.
- Reset mid-frame: send 55 AA 03 12, pulse I_rstn low, then send a good frame -> all outputs 0 during reset, and only the post-reset frame produces a write.
- Busy handshake (ACK enabled): hold I_tx_wbusy = 1 through a good frame, release it after 100 cycles -> O_tx_wreq asserts exactly once, in the first cycle with I_tx_wbusy = 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;
  localparam int FRAME_LEN = 6;
  localparam int STATE_W   = $clog2(FRAME_LEN);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_SOF1, S_ADDR, S_DH, S_DL, S_CHK
  } state_t;

  localparam logic [7:0] SOF0_DEF = 8'h55;
  localparam logic [7:0] SOF1_DEF = 8'hAA;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rsp_t;

  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    return 8'(a + b + c);
  endfunction
endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter; expire is a one-cycle pulse on the cycle the count would reach TIMEOUT_CYC.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 25_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // A byte arriving on the expiry cycle suppresses the pulse.
  assign expire = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr | ~en | expire)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA ADDR DH DL CHK frames into register-write strobes.
// Define UART_FRAME_ACK_EN to return an ACK/NAK byte through the UART transmit request port.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         SYSCLKHZ    = 25_000_000,
  parameter int         TIMEOUT_CYC = SYSCLKHZ / 1000,
  parameter logic [7:0] SOF0        = SOF0_DEF,
  parameter logic [7:0] SOF1        = SOF1_DEF
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic [7:0]  I_rx_data,
  input  logic        I_rx_valid,
  output logic        O_reg_wen,
  output logic [7:0]  O_reg_addr,
  output logic [15:0] O_reg_wdata,
  output logic [7:0]  O_err_cnt,
  output logic        O_tx_wreq,
  output logic [7:0]  O_tx_wdata,
  input  logic        I_tx_wbusy
);
  state_t     state;
  logic [7:0] addr_sh, dh_sh, dl_sh;
  logic       expire, chk_ok;

  assign chk_ok = (I_rx_data == frame_sum(addr_sh, dh_sh, dl_sh));

  uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (I_clk),
    .rst_n  (I_rstn),
    .en     (state != S_IDLE),
    .clr    (I_rx_valid),
    .expire (expire)
  );

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state       <= S_IDLE;
      addr_sh     <= '0;
      dh_sh       <= '0;
      dl_sh       <= '0;
      O_reg_wen   <= 1'b0;
      O_reg_addr  <= '0;
      O_reg_wdata <= '0;
      O_err_cnt   <= '0;
    end else begin
      O_reg_wen <= 1'b0;
      if (I_rx_valid) begin
        case (state)
          S_IDLE: if (I_rx_data == SOF0) state <= S_SOF1;
          // A repeated SOF0 keeps us waiting for SOF1 so "55 55 AA" still syncs.
          S_SOF1: if (I_rx_data == SOF1)      state <= S_ADDR;
                  else if (I_rx_data != SOF0) state <= S_IDLE;
          S_ADDR: begin addr_sh <= I_rx_data; state <= S_DH; end
          S_DH:   begin dh_sh   <= I_rx_data; state <= S_DL; end
          S_DL:   begin dl_sh   <= I_rx_data; state <= S_CHK; end
          S_CHK: begin
            state <= S_IDLE;
            if (chk_ok) begin
              O_reg_wen   <= 1'b1;
              O_reg_addr  <= addr_sh;
              O_reg_wdata <= {dh_sh, dl_sh};
            end else if (O_err_cnt != 8'hFF) begin
              O_err_cnt <= O_err_cnt + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (expire) begin
        state <= S_IDLE;
        if (O_err_cnt != 8'hFF) O_err_cnt <= O_err_cnt + 8'd1;
      end
    end
  end

`ifdef UART_FRAME_ACK_EN
  rsp_t pend;
  logic frame_done;

  assign frame_done = I_rx_valid && (state == S_CHK);
  assign O_tx_wreq  = pend.vld & ~I_tx_wbusy;
  assign O_tx_wdata = pend.data;

  // Newest response wins over one still waiting for the transmitter.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn)         pend     <= '0;
    else if (frame_done) pend     <= '{vld: 1'b1, data: (chk_ok ? ACK_BYTE : NAK_BYTE)};
    else if (O_tx_wreq)  pend.vld <= 1'b0;
  end
`else
  logic unused_busy;
  assign unused_busy = I_tx_wbusy;
  assign O_tx_wreq   = 1'b0;
  assign O_tx_wdata  = '0;
`endif
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed vector table, timeout/reset/busy sequences, random byte stream vs frame model.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int TMO = 25_000_000 / 1000;
`ifdef UART_FRAME_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rstn = 1'b0;
  logic [7:0]  I_rx_data = '0;
  logic        I_rx_valid = 1'b0;
  logic        I_tx_wbusy = 1'b0;
  logic        O_reg_wen, O_tx_wreq;
  logic [7:0]  O_reg_addr, O_err_cnt, O_tx_wdata;
  logic [15:0] O_reg_wdata;

  uart_frame_parser dut (
    .I_clk(I_clk), .I_rstn(I_rstn), .I_rx_data(I_rx_data), .I_rx_valid(I_rx_valid),
    .O_reg_wen(O_reg_wen), .O_reg_addr(O_reg_addr), .O_reg_wdata(O_reg_wdata),
    .O_err_cnt(O_err_cnt), .O_tx_wreq(O_tx_wreq), .O_tx_wdata(O_tx_wdata),
    .I_tx_wbusy(I_tx_wbusy)
  );

  always #5 I_clk = ~I_clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wen_seen = 0, tx_seen = 0, tx_cyc = -1;
  logic [7:0]  last_addr, last_tx;
  logic [15:0] last_wdata;

  // reference model: bytes of the frame being collected plus expected outputs
  logic [7:0]  fb[$];
  int          m_idle;
  logic        m_wen, m_pend;
  logic [7:0]  m_addr, m_err, m_pbyte;
  logic [15:0] m_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    fb.delete();
    m_idle = 0; m_wen = 1'b0; m_pend = 1'b0; m_addr = '0; m_err = '0; m_pbyte = '0; m_wdata = '0;
  endfunction

  function automatic void model_adv(input logic v, input logic [7:0] d, input logic busy);
    logic done, good;
    int   s;
    done = 1'b0; good = 1'b0;
    m_wen = 1'b0;
    if (v) begin
      m_idle = 0;
      if (fb.size() == 0) begin
        if (d == 8'h55) fb.push_back(d);
      end else if (fb.size() == 1) begin
        if (d == 8'hAA) fb.push_back(d);
        else if (d != 8'h55) fb.delete();
      end else begin
        fb.push_back(d);
        if (fb.size() == 6) begin
          s = (int'(fb[2]) + int'(fb[3]) + int'(fb[4])) % 256;
          good = (s == int'(d));
          done = 1'b1;
          if (good) begin
            m_wen = 1'b1; m_addr = fb[2]; m_wdata = {fb[3], fb[4]};
          end else if (m_err != 8'hFF) m_err = m_err + 8'd1;
          fb.delete();
        end
      end
    end else if (fb.size() != 0) begin
      m_idle++;
      if (m_idle >= TMO) begin
        fb.delete(); m_idle = 0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
    if (done) begin m_pend = 1'b1; m_pbyte = good ? 8'h06 : 8'h15; end
    else if (m_pend && !busy) m_pend = 1'b0;
  endfunction

  // One clock: drive after the rising edge, check mid-cycle, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic busy);
    I_rx_valid = v;
    I_rx_data  = v ? d : 8'($urandom);
    I_tx_wbusy = busy;
    @(negedge I_clk);
    chk("regs", {O_reg_wen, O_reg_addr, O_reg_wdata, O_err_cnt}, {m_wen, m_addr, m_wdata, m_err});
`ifdef UART_FRAME_ACK_EN
    chk("tx_wreq", O_tx_wreq, (m_pend && !busy));
    if (m_pend && !busy) chk("tx_wdata", O_tx_wdata, m_pbyte);
`else
    chk("tx_off", {O_tx_wreq, O_tx_wdata}, 0);
`endif
    if (O_reg_wen) begin wen_seen++; last_addr = O_reg_addr; last_wdata = O_reg_wdata; end
    if (O_tx_wreq) begin tx_seen++; last_tx = O_tx_wdata; tx_cyc = cyc; end
    cyc++;
    model_adv(v, I_rx_data, busy);
    @(posedge I_clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input logic busy);
    step(1, 8'h55, busy); step(1, 8'hAA, busy);
    step(1, a, busy); step(1, h, busy); step(1, l, busy); step(1, c, busy);
  endtask

  typedef struct packed {
    logic [3:0]       n;
    logic [0:11][7:0] b;
    logic [1:0]       writes;
    logic [7:0]       addr;
    logic [15:0]      wdata;
    logic [1:0]       errd;
    logic [1:0]       txn;
    logic [7:0]       txb;
  } vec_t;

  vec_t        vt[5];
  logic [7:0]  e0, a, h, l, s;
  int          w0, t0, rel;

  initial begin
    vt[0] = '{4'd6, {8'h55, 8'hAA, 8'h03, 8'h12, 8'h34, 8'h49, {6{8'h00}}}, 2'd1, 8'h03, 16'h1234, 2'd0, 2'd1, 8'h06};
    vt[1] = '{4'd6, {8'h55, 8'hAA, 8'h03, 8'h12, 8'h34, 8'h48, {6{8'h00}}}, 2'd0, 8'h00, 16'h0000, 2'd1, 2'd1, 8'h15};
    vt[2] = '{4'd8, {8'h11, 8'h55, 8'h55, 8'hAA, 8'h01, 8'hAB, 8'hCD, 8'h79, {4{8'h00}}}, 2'd1, 8'h01, 16'hABCD, 2'd0, 2'd1, 8'h06};
    vt[3] = '{4'd12, {8'h55, 8'hAA, 8'h10, 8'h00, 8'h01, 8'h11, 8'h55, 8'hAA, 8'h20, 8'hFF, 8'hFF, 8'h1E},
              2'd2, 8'h20, 16'hFFFF, 2'd0, 2'd2, 8'h06};
    vt[4] = '{4'd7, {8'h55, 8'h12, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h06, {5{8'h00}}}, 2'd0, 8'h00, 16'h0000, 2'd0, 2'd0, 8'h00};

    model_reset();
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    chk("rst_regs", {O_reg_wen, O_reg_addr, O_reg_wdata, O_err_cnt}, 0);
    chk("rst_tx", {O_tx_wreq, O_tx_wdata}, 0);
    @(posedge I_clk); #1;
    I_rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      w0 = wen_seen; t0 = tx_seen; e0 = m_err;
      for (int k = 0; k < int'(vt[i].n); k++) step(1, vt[i].b[k], 1'b0);
      repeat (3) step(0, 8'h00, 1'b0);
      chk($sformatf("vec%0d_writes", i), wen_seen - w0, vt[i].writes);
      if (vt[i].writes != 0) begin
        chk($sformatf("vec%0d_addr", i), last_addr, vt[i].addr);
        chk($sformatf("vec%0d_wdata", i), last_wdata, vt[i].wdata);
      end
      chk($sformatf("vec%0d_err", i), O_err_cnt, e0 + 8'(vt[i].errd));
      chk($sformatf("vec%0d_txn", i), tx_seen - t0, ACK_EN ? int'(vt[i].txn) : 0);
      if (ACK_EN && vt[i].txn != 0) chk($sformatf("vec%0d_txb", i), last_tx, vt[i].txb);
    end

    // timeout after a partial frame, then recovery
    e0 = m_err; w0 = wen_seen;
    step(1, 8'h55, 0); step(1, 8'hAA, 0); step(1, 8'h03, 0);
    repeat (TMO) step(0, 8'h00, 0);
    chk("tmo_err", O_err_cnt, e0 + 8'd1);
    chk("tmo_idle", 64'(dut.state), 64'(S_IDLE));
    send_frame(8'h07, 8'h00, 8'hFF, 8'h06, 0);
    step(0, 8'h00, 0);
    chk("tmo_recov_writes", wen_seen - w0, 1);
    chk("tmo_recov_addr", last_addr, 8'h07);
    chk("tmo_recov_wdata", last_wdata, 16'h00FF);

    // byte landing on the expiry cycle is accepted
    e0 = m_err; w0 = wen_seen;
    step(1, 8'h55, 0);
    repeat (TMO - 1) step(0, 8'h00, 0);
    step(1, 8'hAA, 0); step(1, 8'h01, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h01, 0);
    step(0, 8'h00, 0);
    chk("edge_err", O_err_cnt, e0);
    chk("edge_writes", wen_seen - w0, 1);
    chk("edge_wdata", last_wdata, 16'h0000);

    // reset mid-frame discards the partial frame
    step(1, 8'h55, 0); step(1, 8'hAA, 0); step(1, 8'h03, 0); step(1, 8'h12, 0);
    I_rstn = 1'b0; I_rx_valid = 1'b0;
    #1;
    chk("mid_rst_regs", {O_reg_wen, O_reg_addr, O_reg_wdata, O_err_cnt}, 0);
    chk("mid_rst_tx", {O_tx_wreq, O_tx_wdata}, 0);
    @(posedge I_clk); #1;
    I_rstn = 1'b1;
    model_reset();
    w0 = wen_seen;
    step(1, 8'h34, 0); step(1, 8'h49, 0);
    repeat (2) step(0, 8'h00, 0);
    chk("mid_rst_nowrite", wen_seen - w0, 0);
    send_frame(8'h03, 8'h12, 8'h34, 8'h49, 0);
    step(0, 8'h00, 0);
    chk("post_rst_writes", wen_seen - w0, 1);
    chk("post_rst_wdata", last_wdata, 16'h1234);

`ifdef UART_FRAME_ACK_EN
    t0 = tx_seen;
    send_frame(8'h03, 8'h12, 8'h34, 8'h49, 1);
    repeat (100) step(0, 8'h00, 1);
    chk("busy_hold", tx_seen - t0, 0);
    rel = cyc;
    repeat (5) step(0, 8'h00, 0);
    chk("busy_cnt", tx_seen - t0, 1);
    chk("busy_cyc", tx_cyc, rel);
    chk("busy_byte", last_tx, 8'h06);
`endif

    // random stream: noise, good and bad frames, random gaps and busy
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        step(1, 8'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
        s = 8'((int'(a) + int'(h) + int'(l)) % 256);
        if (kind == 3) s = s ^ 8'($urandom_range(1, 255));
        step(1, 8'h55, ($urandom_range(0, 3) == 0));
        step(1, 8'hAA, ($urandom_range(0, 3) == 0));
        step(1, a, ($urandom_range(0, 3) == 0));
        step(1, h, ($urandom_range(0, 3) == 0));
        step(1, l, ($urandom_range(0, 3) == 0));
        step(1, s, ($urandom_range(0, 3) == 0));
      end
      repeat ($urandom_range(0, 3)) step(0, 8'h00, ($urandom_range(0, 3) == 0));
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
    repeat (3) step(0, 8'h00, 0);
    chk("err_sat", O_err_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
